wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and load scoreboard for the core's register-file write port. Merges single-cycle ALU results and variable-latency LSU load results into one registered write per cycle (`wb_write`/`wb_rd`/`wb_data`), which drives the regfile `write`/`rd`/`rd_data` inputs. Tracks destination registers with outstanding loads so decode can stall on a read-after-load hazard.

## Interface
- `XLEN`, 32: data width.
- `FIFO_DEPTH`, 2: LSU result buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_valid` in 1: ALU result valid.
- `alu_ready` out 1: ALU result accepted this cycle when high with `alu_valid`.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in XLEN: ALU result.
- `lsu_valid` in 1: load result valid.
- `lsu_ready` out 1: low when the FIFO is full.
- `lsu_rd` in 5: load destination register.
- `lsu_data` in XLEN: load data.
- `issue_load` in 1: a load is issued this cycle (scoreboard set).
- `issue_rd` in 5: destination of the issued load.
- `rs1`, `rs2` in 5 each: decode source indices.
- `rs1_pending`, `rs2_pending` out 1 each: source awaits a load.
- `wb_write` out 1: regfile write enable, registered.
- `wb_rd` out 5: regfile write index, registered.
- `wb_data` out XLEN: regfile write data, registered.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: LSU FIFO occupancy.

## Operation
- LSU results enter a FIFO_DEPTH circular FIFO.
  - Push when `lsu_valid && lsu_ready`, with `lsu_ready = (count != FIFO_DEPTH)`.
  - There is no bypass: a load result always spends at least one cycle in the FIFO.
- Per-cycle select, combinational:
  - FIFO full → pop the FIFO head; `alu_ready = 0`.
  - Otherwise `alu_ready = 1`.
    - If `alu_valid`, select the ALU result.
    - Else if the FIFO is non-empty, pop the head.
    - Else select nothing.
- Push and pop in the same cycle are legal when the FIFO is not full; `count` is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Writeback register, updated at each edge:
  - `wb_write <= selected && sel_rd != 0`.
  - `wb_rd` and `wb_data` load the selected values when something is selected and otherwise hold.
  - A result with rd = x0 is still consumed (ALU handshake completes, FIFO pops), but `wb_write` stays 0.
- A 1-bit source flag `wb_from_lsu` is registered alongside the writeback register.
- Scoreboard: a 32-bit `pending` register.
  - Set: `issue_load && issue_rd != 0` sets `pending[issue_rd]`.
  - Clear: `wb_write && wb_from_lsu` clears `pending[wb_rd]`.
  - If set and clear hit the same index in the same cycle, set wins.
  - Bit 0 is never set.
- `rsN_pending = pending[rsN] && !(wb_write && wb_from_lsu && wb_rd == rsN)`. The regfile bypass supplies the data in that cycle, so decode need not stall.
- Issuing a second load to a register already pending is illegal; decode must stall. No checker is built in.
- Reset (async, any time, including mid-operation):
  - FIFO emptied, pointers 0, `fifo_count = 0`.
  - `wb_write = 0`, `wb_rd = 0`, `wb_data = 0`, `wb_from_lsu = 0`, `pending = 0`.
  - Hence `alu_ready = 1`, `lsu_ready = 1`, both `rsN_pending = 0`.
  - In-flight FIFO contents are discarded.

## Timing
- ALU → `wb_write`: 1 cycle (accepted at edge N, write visible in cycle N+1).
- LSU → `wb_write`: minimum 2 cycles (push at edge N, pop at edge N+1 if no ALU result, write in cycle N+2).
- Throughput: one regfile write per cycle.
- Worst-case ALU stall: one cycle per LSU entry drained when the FIFO is full.
- `pending` bit from `issue_load`: visible the cycle after issue; cleared the cycle after the LSU writeback cycle.

## Configuration
- `WB_SCOREBOARD_EN` defined: scoreboard built as specified.
- `WB_SCOREBOARD_EN` undefined:
  - No `pending` register.
  - `rs1_pending = rs2_pending = 0`.
  - `issue_load`/`issue_rd` ignored.
  - `wb_from_lsu` may be removed.
  - Arbitration and FIFO are unchanged.

## Test plan
- **Reset:** assert `rst` mid-stream with 2 FIFO entries → `fifo_count = 0`, `wb_write = 0`, `pending = 0`, `alu_ready = lsu_ready = 1` immediately (async).
- **ALU path:** `alu_valid`, rd = 5, data = 0xDEADBEEF at edge N → cycle N+1 shows `wb_write = 1`, `wb_rd = 5`, `wb_data = 0xDEADBEEF`.
- **Priority/full:**
  - Push LSU rd = 6 and rd = 7 while the ALU is valid every cycle → FIFO reaches 2 and `lsu_ready = 0`.
  - Next cycle `alu_ready = 0` and rd 6 is written; then `alu_ready = 1` again and the ALU result is written.
  - No result is lost or reordered within the LSU stream.
- **x0:** ALU rd = 0 with data 0x1234 → `alu_ready = 1`, `wb_write` stays 0; LSU rd = 0 pops the FIFO with no write.
- **Scoreboard:**
  - `issue_load` rd = 9 → `rs1 = 9` pending from the next cycle.
  - In the LSU writeback cycle for rd 9, `rs1_pending = 0`; the bit is clear afterwards.
  - Simultaneous issue and clear of rd 9 → bit remains set.
- **Wrap:** 10 back-to-back LSU results (rd 1..10, data = rd×0x11) with no ALU traffic → written in order, pointers wrap correctly, `fifo_count` never exceeds 2.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of all non-clock signals between the writeback arbiter and its
// neighbours: ALU/LSU result handshakes, load issue, decode source lookups,
// the registered regfile write port and the LSU FIFO occupancy.
// The slave modport is the arbiter's view; master is the surrounding core.
interface wb_arbiter_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            issue_load;
    logic [4:0]      issue_rd;

    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_pending;
    logic            rs2_pending;

    logic            wb_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic [CW-1:0]   fifo_count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_load, issue_rd, rs1, rs2,
        output alu_ready, lsu_ready, rs1_pending, rs2_pending,
        output wb_write, wb_rd, wb_data, fifo_count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_load, issue_rd, rs1, rs2,
        input  alu_ready, lsu_ready, rs1_pending, rs2_pending,
        input  wb_write, wb_rd, wb_data, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter and load scoreboard for the regfile write port.
// ALU results are written one cycle after acceptance; LSU results always pass
// through a FIFO_DEPTH-entry circular FIFO and are drained whenever the ALU is
// idle, or forcibly (stalling the ALU) when the FIFO is full.
// Optional feature macro: WB_SCOREBOARD_EN builds the 32-bit pending-load
// scoreboard; without it rs1_pending/rs2_pending are tied low.
module wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    // FIFO storage and control
    logic [4:0]      fifo_rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // Selection result
    logic            sel;
    logic            sel_lsu;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Writeback register
    logic            wb_write_q, wb_write_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_from_lsu_q, wb_from_lsu_d;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.lsu_valid && !full;

    assign bus.alu_ready  = !full;
    assign bus.lsu_ready  = !full;
    assign bus.fifo_count = count_q;
    assign bus.wb_write   = wb_write_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.wb_data    = wb_data_q;

    // Arbitration: full FIFO drains first, then ALU, then any buffered load
    always_comb begin
        pop      = 1'b0;
        sel      = 1'b0;
        sel_lsu  = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (full) begin
            pop = 1'b1;
        end else if (bus.alu_valid) begin
            sel      = 1'b1;
            sel_rd   = bus.alu_rd;
            sel_data = bus.alu_data;
        end else if (!empty) begin
            pop = 1'b1;
        end
        if (pop) begin
            sel      = 1'b1;
            sel_lsu  = 1'b1;
            sel_rd   = fifo_rd_mem[rd_ptr_q];
            sel_data = fifo_data_mem[rd_ptr_q];
        end
    end

    // Next-state for FIFO pointers/occupancy and the writeback register
    always_comb begin
        wr_ptr_d = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = CW'(count_q + 1'b1);
        end else if (pop && !push) begin
            count_d = CW'(count_q - 1'b1);
        end

        wb_write_d    = sel && (sel_rd != 5'd0);
        wb_rd_d       = sel ? sel_rd   : wb_rd_q;
        wb_data_d     = sel ? sel_data : wb_data_q;
        wb_from_lsu_d = sel ? sel_lsu  : wb_from_lsu_q;
    end

    // FIFO payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= bus.lsu_rd;
            fifo_data_mem[wr_ptr_q] <= bus.lsu_data;
        end
    end

    // Control state and writeback register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wb_write_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_from_lsu_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wb_write_q    <= wb_write_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_from_lsu_q <= wb_from_lsu_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending_q, pending_d;
    logic        lsu_clr;

    assign lsu_clr = wb_write_q && wb_from_lsu_q;

    // Scoreboard update: clear on LSU writeback, then set on issue so set wins
    always_comb begin
        pending_d = pending_q;
        if (lsu_clr) begin
            pending_d[wb_rd_q] = 1'b0;
        end
        if (bus.issue_load && (bus.issue_rd != 5'd0)) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // The writeback cycle itself is covered by the regfile bypass
    assign bus.rs1_pending = pending_q[bus.rs1] && !(lsu_clr && (wb_rd_q == bus.rs1));
    assign bus.rs2_pending = pending_q[bus.rs2] && !(lsu_clr && (wb_rd_q == bus.rs2));
`else
    logic unused_sb;
    assign unused_sb = ^{bus.issue_load, bus.issue_rd, bus.rs1, bus.rs2, wb_from_lsu_q};

    assign bus.rs1_pending = 1'b0;
    assign bus.rs2_pending = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all compared each cycle against a queue-based model.
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) bus ();

    wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        q[$];
    bit          exp_write;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    bit          exp_from;
    bit          pend[32];

    // Observation helpers
    bit   log_en = 1'b0;
    ent_t wlog[$];
    int   max_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit exp_rs_pend(input logic [4:0] r);
        return SB && pend[r] && !(exp_write && exp_from && exp_rd == r);
    endfunction

    task automatic model_reset();
        q.delete();
        exp_write = 1'b0;
        exp_rd    = '0;
        exp_data  = '0;
        exp_from  = 1'b0;
        foreach (pend[i]) pend[i] = 1'b0;
    endtask

    task automatic compare_all();
        chk("fifo_count", bus.fifo_count, q.size());
        chk("alu_ready", bus.alu_ready, q.size() != DEPTH);
        chk("lsu_ready", bus.lsu_ready, q.size() != DEPTH);
        chk("wb_write", bus.wb_write, exp_write);
        chk("wb_rd", bus.wb_rd, exp_rd);
        chk("wb_data", bus.wb_data, exp_data);
        chk("rs1_pending", bus.rs1_pending, exp_rs_pend(bus.rs1));
        chk("rs2_pending", bus.rs2_pending, exp_rs_pend(bus.rs2));
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        bit          full;
        bit          sel;
        bit          from;
        logic [4:0]  srd;
        logic [31:0] sdata;
        ent_t        e;
        full = (q.size() == DEPTH);
        sel  = 1'b0;
        from = 1'b0;
        srd  = '0;
        sdata = '0;
        if (full || (!bus.alu_valid && q.size() > 0)) begin
            e = q.pop_front();
            sel = 1'b1; from = 1'b1; srd = e.rd; sdata = e.data;
        end else if (bus.alu_valid) begin
            sel = 1'b1; srd = bus.alu_rd; sdata = bus.alu_data;
        end
        if (SB) begin
            if (exp_write && exp_from) pend[exp_rd] = 1'b0;
            if (bus.issue_load && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
        end
        if (bus.lsu_valid && !full) begin
            e.rd = bus.lsu_rd;
            e.data = bus.lsu_data;
            q.push_back(e);
        end
        exp_write = sel && (srd != 0);
        if (sel) begin
            exp_rd   = srd;
            exp_data = sdata;
            exp_from = from;
        end
    endtask

    // Called just after a falling edge with inputs driven; returns at the next one
    task automatic step();
        ent_t e;
        #1;
        compare_all();
        if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (log_en && bus.wb_write) begin
            e.rd = bus.wb_rd;
            e.data = bus.wb_data;
            wlog.push_back(e);
        end
    endtask

    task automatic idle();
        bus.alu_valid  = 1'b0;
        bus.alu_rd     = '0;
        bus.alu_data   = '0;
        bus.lsu_valid  = 1'b0;
        bus.lsu_rd     = '0;
        bus.lsu_data   = '0;
        bus.issue_load = 1'b0;
        bus.issue_rd   = '0;
        bus.rs1        = '0;
        bus.rs2        = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_wb_write", bus.wb_write, 0);
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_lsu_ready", bus.lsu_ready, 1);

        // ALU path
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        chk("alu_wb_write", bus.wb_write, 1);
        chk("alu_wb_rd", bus.wb_rd, 5);
        chk("alu_wb_data", bus.wb_data, 32'hDEADBEEF);

        // Priority / full
        bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h66;
        step();
        bus.alu_rd = 5'd21; bus.alu_data = 32'h21;
        bus.lsu_rd = 5'd7; bus.lsu_data = 32'h77;
        step();
        bus.lsu_valid = 1'b0;
        bus.alu_rd = 5'd22; bus.alu_data = 32'h2222;
        #1;
        chk("full_count", bus.fifo_count, 2);
        chk("full_lsu_ready", bus.lsu_ready, 0);
        chk("full_alu_ready", bus.alu_ready, 0);
        step();
        chk("drain_rd6", bus.wb_rd, 6);
        chk("drain_data6", bus.wb_data, 32'h66);
        step();
        chk("alu_after_stall", bus.wb_rd, 22);
        idle();
        step();
        chk("drain_rd7", bus.wb_rd, 7);

        // x0 destinations
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        #1;
        chk("x0_alu_ready", bus.alu_ready, 1);
        step();
        chk("x0_alu_no_write", bus.wb_write, 0);
        idle();
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'hABC;
        step();
        idle();
        step();
        chk("x0_lsu_no_write", bus.wb_write, 0);
        chk("x0_lsu_popped", bus.fifo_count, 0);

        // Scoreboard set, bypass cycle, set-wins, clear
        idle();
        bus.issue_load = 1'b1; bus.issue_rd = 5'd9; bus.rs1 = 5'd9;
        step();
        idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd9;
        #1;
        chk("sb_rs1_set", bus.rs1_pending, SB);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
        step();
        idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd9;
        step();
        #1;
        chk("sb_wb_rd9", bus.wb_rd, 9);
        chk("sb_bypass_rs1", bus.rs1_pending, 0);
        bus.issue_load = 1'b1; bus.issue_rd = 5'd9;
        step();
        idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd9;
        #1;
        chk("sb_set_wins", bus.rs2_pending, SB);
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h199;
        step();
        idle(); bus.rs1 = 5'd9; bus.rs2 = 5'd9;
        step();
        step();
        #1;
        chk("sb_cleared", bus.rs1_pending, 0);

        // Asynchronous reset mid-stream with two FIFO entries and a pending load
        idle();
        bus.issue_load = 1'b1; bus.issue_rd = 5'd12;
        step();
        idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h3;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'h13;
        step();
        bus.lsu_rd = 5'd14; bus.lsu_data = 32'h14;
        step();
        idle(); bus.rs1 = 5'd12;
        #1;
        chk("pre_rst_count", bus.fifo_count, 2);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_count", bus.fifo_count, 0);
        chk("async_rst_wb_write", bus.wb_write, 0);
        chk("async_rst_alu_ready", bus.alu_ready, 1);
        chk("async_rst_lsu_ready", bus.lsu_ready, 1);
        chk("async_rst_rs1_pending", bus.rs1_pending, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Wrap: ten back-to-back loads, no ALU traffic
        idle();
        wlog.delete();
        max_cnt = 0;
        log_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_rd    = 5'(i);
            bus.lsu_data  = 32'(i * 32'h11);
            step();
        end
        idle();
        repeat (3) step();
        log_en = 1'b0;
        chk("wrap_write_count", wlog.size(), 10);
        for (int i = 0; i < wlog.size() && i < 10; i++) begin
            chk("wrap_rd", wlog[i].rd, i + 1);
            chk("wrap_data", wlog[i].data, (i + 1) * 32'h11);
        end
        chk("wrap_max_count_le2", max_cnt <= 2, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ird;
            bus.alu_valid = ($urandom_range(0, 99) < 45);
            bus.alu_rd    = 5'($urandom_range(0, 15));
            bus.alu_data  = $urandom;
            bus.lsu_valid = ($urandom_range(0, 99) < 55);
            bus.lsu_rd    = 5'($urandom_range(0, 15));
            bus.lsu_data  = $urandom;
            ird = 5'($urandom_range(0, 15));
            bus.issue_rd   = ird;
            bus.issue_load = ($urandom_range(0, 99) < 30) && !pend[ird];
            bus.rs1 = 5'($urandom_range(0, 15));
            bus.rs2 = 5'($urandom_range(0, 15));
            step();
        end

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
